// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART transmitter (and future receiver).
package uart_pkg;

    // Transmitter frame sequencer states.
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_e;

    // Parity_mode encodings; 2'b11 is treated the same as PAR_NONE.
    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    // Legal range of data bits per frame.
    localparam int WORD_SIZE_MIN = 5;
    localparam int WORD_SIZE_MAX = 9;

    // True when the frame carries a parity bit.
    function automatic logic parity_enabled(input logic [1:0] mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..div and pulses tick on the final clock of each bit.
module uart_baud_gen #(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 Clock,
    input  logic                 rst,
    input  logic                 restart,
    input  logic [DIV_WIDTH-1:0] div,
    output logic                 tick
);

    logic [DIV_WIDTH-1:0] count;

    assign tick = (count == div);

    // Count up; reload to zero on reset, on an explicit restart and after every tick.
    always_ff @(posedge Clock) begin
        // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
        if (rst || restart || tick)
            count <= '0;
        else
            count <= count + 1'b1;
    end

endmodule

// File: rtl/uart_xmtr_cfg.sv
// Runtime-configurable UART transmitter with one-deep holding register and
// per-frame latched parity / stop / baud configuration.
module uart_xmtr_cfg #(
    parameter int WORD_SIZE = 8,
    parameter int DIV_WIDTH = 16
) (
    input  logic                 Clock,
    input  logic                 rst,
    input  logic [WORD_SIZE-1:0] Data_bus,
    input  logic                 Data_valid,
    output logic                 Data_ready,
    input  logic [1:0]           Parity_mode,
    input  logic                 Two_stop,
    input  logic [DIV_WIDTH-1:0] Baud_div,
    output logic                 Serial_out,
    output logic                 Busy,
    output logic                 Frame_done
);

    import uart_pkg::*;

    localparam int                BIT_W    = $clog2(WORD_SIZE + 1);
    localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(WORD_SIZE);

    if (WORD_SIZE < WORD_SIZE_MIN || WORD_SIZE > WORD_SIZE_MAX) begin : g_bad_word_size
        $error("uart_xmtr_cfg: WORD_SIZE must be within 5..9");
    end

    uart_state_e          state, state_n;
    logic                 hold_full;
    logic [WORD_SIZE-1:0] hold_data;
    logic [WORD_SIZE-1:0] shreg, shreg_n;
    logic [BIT_W-1:0]     bit_cnt, bit_cnt_n;
    logic                 stop_cnt, stop_cnt_n;
    logic                 ser_q, ser_n;

    // Configuration frozen for the frame in flight.
    logic [1:0]           par_mode_l;
    logic                 two_stop_l;
    logic [DIV_WIDTH-1:0] div_l;
    logic                 par_bit_l;

    logic                 tick;
    logic                 load;
    logic                 done;
    logic                 accept;

    assign accept     = Data_valid && !hold_full;
    assign Data_ready = !hold_full;
    assign Busy       = (state != IDLE);
    assign Serial_out = ser_q;
    assign Frame_done = done;

    uart_baud_gen #(.DIV_WIDTH(DIV_WIDTH)) u_baud (
        .Clock   (Clock),
        .rst     (rst),
        .restart (load),
        .div     (div_l),
        .tick    (tick)
    );

    // Holding-register occupancy: set on accept, cleared when the word moves to the shifter.
    always_ff @(posedge Clock) begin
        if (rst)
            hold_full <= 1'b0;
        else if (load)
            hold_full <= 1'b0;
        else if (accept)
            hold_full <= 1'b1;
    end

    // Holding-register data, captured on accept.
    always_ff @(posedge Clock) begin
        // NOTE: no reset on the data word; it is only ever read while hold_full qualifies it.
        if (accept)
            hold_data <= Data_bus;
    end

    // Latch per-frame configuration and precompute the parity bit at transfer.
    always_ff @(posedge Clock) begin
        if (rst) begin
            par_mode_l <= PAR_NONE;
            two_stop_l <= 1'b0;
            div_l      <= '0;
            par_bit_l  <= 1'b0;
        end else if (load) begin
            par_mode_l <= Parity_mode;
            two_stop_l <= Two_stop;
            div_l      <= Baud_div;
            par_bit_l  <= (^hold_data) ^ (Parity_mode == PAR_ODD);
        end
    end

    // Sequencer and line registers.
    always_ff @(posedge Clock) begin
        if (rst) begin
            state    <= IDLE;
            shreg    <= '0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            ser_q    <= 1'b1;
        end else begin
            state    <= state_n;
            shreg    <= shreg_n;
            bit_cnt  <= bit_cnt_n;
            stop_cnt <= stop_cnt_n;
            ser_q    <= ser_n;
        end
    end

    // Next-state, next line level, transfer and frame-done decode.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_n    = state;
        shreg_n    = shreg;
        bit_cnt_n  = bit_cnt;
        stop_cnt_n = stop_cnt;
        ser_n      = ser_q;
        load       = 1'b0;
        done       = 1'b0;

        unique case (state)
            IDLE: begin
                load = hold_full;
            end
            START: begin
                if (tick) begin
                    state_n   = DATA;
                    ser_n     = shreg[0];
                    shreg_n   = {1'b0, shreg[WORD_SIZE-1:1]};
                    bit_cnt_n = BIT_W'(1);
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_cnt == LAST_BIT) begin
                        if (parity_enabled(par_mode_l)) begin
                            state_n = PARITY;
                            ser_n   = par_bit_l;
                        end else begin
                            state_n    = STOP;
                            ser_n      = 1'b1;
                            stop_cnt_n = 1'b0;
                        end
                    end else begin
                        ser_n     = shreg[0];
                        shreg_n   = {1'b0, shreg[WORD_SIZE-1:1]};
                        bit_cnt_n = bit_cnt + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    state_n    = STOP;
                    ser_n      = 1'b1;
                    stop_cnt_n = 1'b0;
                end
            end
            STOP: begin
                if (tick) begin
                    if (two_stop_l && !stop_cnt) begin
                        stop_cnt_n = 1'b1;
                    end else begin
                        done = 1'b1;
                        if (hold_full)
                            load = 1'b1;
                        else
                            state_n = IDLE;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                ser_n   = 1'b1;
            end
        endcase

        // Transfer holding -> shifter; the start bit goes out from the next clock.
        if (load) begin
            state_n    = START;
            ser_n      = 1'b0;
            shreg_n    = hold_data;
            bit_cnt_n  = '0;
            stop_cnt_n = 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_xmtr_cfg.sv
// Self-checking bench for uart_xmtr_cfg: per-cycle line-level reference model
// plus hand-computed frame captures for the directed scenarios.
module tb_uart_xmtr_cfg;

    localparam int WS = 8;
    localparam int DW = 16;

    logic          Clock = 1'b0;
    logic          rst = 1'b1;
    logic [WS-1:0] Data_bus = '0;
    logic          Data_valid = 1'b0;
    logic          Data_ready;
    logic [1:0]    Parity_mode = 2'b00;
    logic          Two_stop = 1'b0;
    logic [DW-1:0] Baud_div = 16'd3;
    logic          Serial_out;
    logic          Busy;
    logic          Frame_done;

    int n_checks = 0;
    int n_pass   = 0;

    uart_xmtr_cfg #(.WORD_SIZE(WS), .DIV_WIDTH(DW)) dut (
        .Clock       (Clock),
        .rst         (rst),
        .Data_bus    (Data_bus),
        .Data_valid  (Data_valid),
        .Data_ready  (Data_ready),
        .Parity_mode (Parity_mode),
        .Two_stop    (Two_stop),
        .Baud_div    (Baud_div),
        .Serial_out  (Serial_out),
        .Busy        (Busy),
        .Frame_done  (Frame_done)
    );

    initial forever #5 Clock = ~Clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        $display("FAIL %s: timed out waiting for DUT at %0t", name, $time);
    endtask

    // ---------------- reference model ----------------
    // line_q holds the expected line level for the current and all later
    // cycles of the frame(s) already committed; empty means the line is idle.
    logic          line_q[$];
    bit            m_full = 1'b0;
    logic [WS-1:0] m_hold = '0;

    function automatic void push_frame(input logic [WS-1:0] d, input logic [1:0] pm,
                                       input logic ts, input logic [DW-1:0] bd);
        logic bits[$];
        bits.push_back(1'b0);
        for (int i = 0; i < WS; i++) bits.push_back(d[i]);
        if (pm == 2'b01) bits.push_back(^d);
        if (pm == 2'b10) bits.push_back(~^d);
        bits.push_back(1'b1);
        if (ts) bits.push_back(1'b1);
        foreach (bits[i])
            for (int k = 0; k <= int'(bd); k++) line_q.push_back(bits[i]);
    endfunction

    always @(posedge Clock) begin : model
        bit ready_before;
        ready_before = !m_full;
        if (rst) begin
            line_q.delete();
            m_full = 1'b0;
        end else begin
            if (line_q.size() != 0) void'(line_q.pop_front());
            if (line_q.size() == 0 && m_full) begin
                push_frame(m_hold, Parity_mode, Two_stop, Baud_div);
                m_full = 1'b0;
            end
            if (Data_valid && ready_before) begin
                m_hold = Data_bus;
                m_full = 1'b1;
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge Clock) begin : compare
        check("serial_out", 32'(Serial_out), 32'((line_q.size() != 0) ? line_q[0] : 1'b1));
        check("busy",       32'(Busy),       32'(line_q.size() != 0));
        check("frame_done", 32'(Frame_done), 32'(line_q.size() == 1));
        check("data_ready", 32'(Data_ready), 32'(!m_full));
    end

    // ---------------- stimulus helpers ----------------
    task automatic randomize_cfg();
        Parity_mode = 2'($urandom_range(0, 3));
        Two_stop    = 1'($urandom_range(0, 1));
        Baud_div    = DW'($urandom_range(0, 3));
    endtask

    // Offer one word and hold it until the handshake completes.
    task automatic send_word(input logic [WS-1:0] d, input bit jitter);
        bit r;
        int g;
        g = 0;
        Data_bus   = d;
        Data_valid = 1'b1;
        forever begin
            r = Data_ready;
            @(posedge Clock);
            #1;
            if (r) break;
            if (jitter && $urandom_range(0, 7) == 0) randomize_cfg();
            g++;
            if (g > 2000) begin
                timeout_fail("send_word");
                break;
            end
        end
        Data_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        do begin
            @(negedge Clock);
            g++;
        end while ((Busy || !Data_ready) && g < 3000);
        if (Busy || !Data_ready) timeout_fail("wait_idle");
    endtask

    // Record the line from the first busy cycle through the nframes-th Frame_done,
    // then compare length, continuity and the mid-bit levels against a literal.
    task automatic capture(input string name, input int per, input int nbits,
                           input int nframes, input logic [31:0] lit);
        logic s[$];
        int   busy_low;
        int   done_seen;
        int   g;
        busy_low  = 0;
        done_seen = 0;
        g         = 0;
        @(negedge Clock);
        while (!Busy && g < 1000) begin
            @(negedge Clock);
            g++;
        end
        if (!Busy) begin
            timeout_fail({name, "_start"});
            return;
        end
        g = 0;
        while (g < 5000) begin
            s.push_back(Serial_out);
            if (!Busy) busy_low++;
            if (Frame_done) done_seen++;
            if (done_seen == nframes) break;
            @(negedge Clock);
            g++;
        end
        check({name, "_len"}, 32'(s.size()), 32'(nbits * per));
        check({name, "_gap"}, 32'(busy_low), 32'd0);
        for (int i = 0; i < nbits; i++)
            if (i * per + per / 2 < s.size())
                check($sformatf("%s_bit%0d", name, i), 32'(s[i * per + per / 2]),
                      32'(lit[nbits - 1 - i]));
    endtask

    // ---------------- directed and random scenarios ----------------
    initial begin
        int g;

        repeat (3) @(posedge Clock);
        @(negedge Clock);
        check("rst_serial", 32'(Serial_out), 32'd1);
        check("rst_ready",  32'(Data_ready), 32'd1);
        check("rst_busy",   32'(Busy),       32'd0);
        check("rst_done",   32'(Frame_done), 32'd0);
        rst = 1'b0;

        // 1: A5, no parity, one stop, 4 clocks per bit.
        Parity_mode = 2'b00; Two_stop = 1'b0; Baud_div = 16'd3;
        send_word(8'hA5, 1'b0);
        capture("t1", 4, 10, 1, 32'b0101001011);
        @(negedge Clock);
        check("t1_busy_after", 32'(Busy), 32'd0);

        // 2: even then odd parity.
        Parity_mode = 2'b01;
        send_word(8'hA5, 1'b0);
        capture("t2_even", 4, 11, 1, 32'b01010010101);
        wait_idle();
        Parity_mode = 2'b10;
        send_word(8'hA5, 1'b0);
        capture("t2_odd", 4, 11, 1, 32'b01010010111);
        wait_idle();

        // 3: one clock per bit, back-to-back with Data_valid held.
        Parity_mode = 2'b00; Baud_div = 16'd0;
        fork
            capture("t3", 1, 20, 2, 32'b00000000010111111111);
            begin
                send_word(8'h00, 1'b0);
                send_word(8'hFF, 1'b0);
            end
        join
        wait_idle();

        // 4: two stop bits; config changes mid-frame must not affect it.
        Two_stop = 1'b1; Baud_div = 16'd1;
        fork
            capture("t4", 2, 11, 1, 32'b00011110011);
            begin
                send_word(8'h3C, 1'b0);
                repeat (5) @(posedge Clock);
                #1;
                Two_stop = 1'b0; Baud_div = 16'd5; Parity_mode = 2'b01;
            end
        join
        wait_idle();

        // 5: three words offered back-to-back.
        Two_stop = 1'b0; Baud_div = 16'd1; Parity_mode = 2'b00;
        fork
            capture("t5", 2, 30, 3, 32'b001001000100010110010011010101);
            begin
                send_word(8'h12, 1'b0);
                send_word(8'h34, 1'b0);
                send_word(8'h56, 1'b0);
            end
        join
        wait_idle();

        // 6: reset during data bit 3, then a clean frame.
        Baud_div = 16'd3;
        send_word(8'h5A, 1'b0);
        g = 0;
        do begin
            @(negedge Clock);
            g++;
        end while (!Busy && g < 100);
        if (!Busy) timeout_fail("t6_start");
        repeat (17) @(negedge Clock);
        rst = 1'b1;
        @(negedge Clock);
        check("t6_serial", 32'(Serial_out), 32'd1);
        check("t6_busy",   32'(Busy),       32'd0);
        check("t6_ready",  32'(Data_ready), 32'd1);
        check("t6_done",   32'(Frame_done), 32'd0);
        rst = 1'b0;
        send_word(8'hC3, 1'b0);
        capture("t6_after", 4, 10, 1, 32'b0110000111);
        wait_idle();

        // Random words, configurations, gaps and mid-frame config churn.
        for (int n = 0; n < 40; n++) begin
            randomize_cfg();
            send_word(WS'($urandom), 1'b1);
            repeat ($urandom_range(0, 3)) begin
                @(posedge Clock);
                #1;
            end
        end
        wait_idle();
        repeat (3) @(negedge Clock);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_xmtr_cfg.md
Name: uart_xmtr_cfg

Overview:
Parametrised, runtime-configurable UART transmitter. Successor to the fixed 8-bit transmitter, with:
- configurable word size
- on-chip baud divider
- parity none/even/odd and 1 or 2 stop bits
- valid/ready host handshake with a one-deep holding register, allowing back-to-back frames with no idle gap

Sits between the host bus and the serial line. Drives the line directly.

Parameters:
WORD_SIZE, 8, data bits per frame; legal range 5..9
DIV_WIDTH, 16, width of Baud_div; bit period = Baud_div+1 clocks

Ports:
Clock  input  1  bit-rate system clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
Data_bus  input  WORD_SIZE  word to transmit; sent LSB first
Data_valid  input  1  host offers Data_bus
Data_ready  output  1  holding register empty; word accepted on the edge where Data_valid && Data_ready
Parity_mode  input  2  00 none, 01 even, 10 odd, 11 treated as none
Two_stop  input  1  1 = two stop bits, 0 = one stop bit
Baud_div  input  DIV_WIDTH  clocks per bit minus one
Serial_out  output  1  registered line output; idles high
Busy  output  1  high while the FSM is not IDLE
Frame_done  output  1  one-cycle pulse on the last clock of the final stop bit

Behaviour:
Reset:
- rst sampled at a rising edge forces: Serial_out=1, Data_ready=1, Busy=0, Frame_done=0, FSM=IDLE.
- Holding register is emptied and counters are zeroed.
- Applies mid-frame too: the line returns high on the edge following rst; the partial frame is abandoned; no Frame_done.

Handshake:
- Word accepted at edge N is written to the holding register; Data_ready=0 after N.
- Holding register is freed on the edge the word transfers to the shift register.
- Data_ready may be high while Busy=1.
- Data_valid with Data_ready=0 is ignored; the host must hold the word.

Frame latching:
- Transfer occurs when the FSM is IDLE with holding full, or at the end of the last stop bit with holding full.
- On transfer, Parity_mode, Two_stop and Baud_div are latched for the whole frame. Changes mid-frame have no effect.

Latency:
- With the FSM IDLE, the word accepted at edge N transfers at edge N+1.
- Serial_out=0 (start bit) from edge N+1.

FSM states: IDLE, START, DATA, PARITY, STOP. A bit lasts exactly Baud_div+1 clocks (latched value); a bit tick occurs on its final clock.
- IDLE -> START: holding full.
- START -> DATA: tick.
- DATA: shifts one bit per tick. After WORD_SIZE bits:
  - -> PARITY if mode is even or odd
  - -> STOP otherwise
- PARITY -> STOP: tick.
  - Even parity bit = XOR of the data bits.
  - Odd parity bit = its inverse.
- STOP: one or two bit periods of 1. On the final tick, Frame_done=1 that clock, then:
  - -> START if holding is full (no idle gap; start bit appears the next clock)
  - -> IDLE otherwise

Widths and timing:
- Bit counter is $clog2(WORD_SIZE+1) bits.
- Baud counter is DIV_WIDTH bits. It reloads to 0 on entering START and on every tick; no wrap beyond Baud_div.
- Baud_div=0 gives one clock per bit, legal.
- Frame length = (1 + WORD_SIZE + P + S)·(Baud_div+1) clocks, where P ∈ {0,1} and S ∈ {1,2}.

Simultaneous events:
- Accept and transfer on the same edge (holding full, FSM taking the word, Data_valid high) is not possible, because Data_ready=0 that cycle.
- The host's next word is accepted on the following edge.

Decomposition:
- Package uart_pkg holds:
  - FSM state enum: IDLE, START, DATA, PARITY, STOP
  - parity-mode constants PAR_NONE, PAR_EVEN, PAR_ODD
  - WORD_SIZE legal-range check constants
- Sub-module uart_baud_gen: DIV_WIDTH counter with synchronous restart and a tick output; reused by the future receiver.

Test Plan:
1. WORD_SIZE=8, Baud_div=3, parity none, one stop, send 8'hA5 -> Serial_out = 0,1,0,1,0,0,1,0,1,1, each held 4 clocks. 40-clock frame; Frame_done high on clock 40; Busy low after.
2. Same word with Parity_mode=01, then 10 -> parity bit 0 (even), then 1 (odd), inserted before stop. 44 clocks each.
3. Baud_div=0, send 8'h00 then 8'hFF back-to-back with Data_valid held -> 20 contiguous clocks with no idle bit between the stop bit and the second start bit. Data_ready rises again one clock after each transfer.
4. Two_stop=1, Baud_div=1, 8'h3C -> stop level high for 4 clocks. Toggling Two_stop and Baud_div mid-frame leaves that frame unchanged.
5. Three words offered back-to-back -> first transfers, second sits in holding, Data_ready=0 for the third until the first frame's last stop tick. All three appear in order.
6. Assert rst during data bit 3 -> Serial_out=1, Busy=0, Data_ready=1 from the next edge. No Frame_done. A new word afterwards transmits correctly.
